pacing_scheduler: RTL and testbench

//  Sequences the RTLola monitor (topEntity): queues input events (x_has/x_data) and

---
 rtl/pacing_pkg.sv | 29 ++
 rtl/pacing_event_fifo.sv | 42 ++++
 rtl/pacing_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pacing_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pacing_pkg.sv
// Shared types and helpers for the RTLola pacing scheduler.
// Optional feature macro: PACING_TIMESTAMP_EN (adds a 64-bit timestamp to every task).
package pacing_pkg;

    localparam int NUM_INPUTS = 3;
    localparam int DATA_W     = 32;
    localparam int CLK_HZ     = 100_000_000;
`ifdef PACING_TIMESTAMP_EN
    localparam int TIME_W     = 64;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
`ifdef PACING_TIMESTAMP_EN
        logic [TIME_W-1:0]            stamp;
`endif
        logic [NUM_INPUTS-1:0]        has;
        logic [NUM_INPUTS*DATA_W-1:0] data;
    } task_t;

    function automatic int us_to_cycles(input int us);
        return (CLK_HZ / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/pacing_event_fifo.sv
// Synchronous event queue: DEPTH words (power of two), extra pointer bit tells full from empty.
module pacing_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/pacing_scheduler.sv
// Queues input events, generates periodic deadlines and issues one task at a time to topEntity.
// Optional feature macro: PACING_TIMESTAMP_EN (mon_time port and timestamp storage).
module pacing_scheduler
    import pacing_pkg::*;
#(
    parameter int NUM_PERIODS = 2,
    parameter int PERIOD0_CYC = us_to_cycles(100),
    parameter int PERIOD1_CYC = us_to_cycles(500),
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_INPUTS*DATA_W-1:0] x_data,
    input  logic [NUM_INPUTS-1:0]        x_has,
    output logic                         in_ready,
    output logic                         mon_valid,
    input  logic                         mon_ready,
    output logic [NUM_INPUTS*DATA_W-1:0] mon_data,
    output logic [NUM_INPUTS-1:0]        mon_has,
    output logic [NUM_PERIODS-1:0]       mon_pace,
`ifdef PACING_TIMESTAMP_EN
    output logic [TIME_W-1:0]            mon_time,
`endif
    output logic                         overflow,
    output logic                         deadline_miss
);

    function automatic int period_cyc(input int k);
        return (k == 0) ? PERIOD0_CYC : PERIOD1_CYC;
    endfunction

    state_t                 state_q, state_d;
    task_t                  fifo_wdata, fifo_rdata, task_q, task_d;
    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [31:0]            cnt_q [NUM_PERIODS];
    logic [31:0]            cnt_d [NUM_PERIODS];
    logic [NUM_PERIODS-1:0] wrap, pend_kept, pend_q, pend_d, pace_q, pace_d;
    logic                   used_q, used_d, overflow_q, overflow_d, miss_q, miss_d;
    logic                   capture, handshake, load;

    assign capture   = en && |x_has;
    assign in_ready  = !fifo_full;
    assign fifo_push = capture && !fifo_full;
    assign handshake = (state_q == ISSUE) && mon_ready;
    assign fifo_pop  = handshake && used_q;
    assign load      = (state_q == IDLE) && (!fifo_empty || |pend_q);

`ifdef PACING_TIMESTAMP_EN
    logic [TIME_W-1:0] ts_q, pend_ts_q, pend_ts_d;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fifo_wdata     = '0;
        fifo_wdata.has = x_has;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (x_has[i]) fifo_wdata.data[i*DATA_W +: DATA_W] = x_data[i*DATA_W +: DATA_W];
        end
`ifdef PACING_TIMESTAMP_EN
        fifo_wdata.stamp = ts_q;
`endif
    end

    pacing_event_fifo #(
        .WIDTH ($bits(task_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        for (int k = 0; k < NUM_PERIODS; k++) begin
            cnt_d[k] = cnt_q[k];
            wrap[k]  = 1'b0;
            if (en) begin
                if (cnt_q[k] == 32'(period_cyc(k) - 1)) begin
                    cnt_d[k] = '0;
                    wrap[k]  = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 32'd1;
                end
            end
        end
    end

    // A wrap in the same cycle as the clearing handshake re-arms its pending bit.
    always_comb begin
        pend_kept  = handshake ? (pend_q & ~pace_q) : pend_q;
        pend_d     = pend_kept | wrap;
        overflow_d = overflow_q | (capture && fifo_full);
        miss_d     = miss_q | (|(wrap & pend_q));
`ifdef PACING_TIMESTAMP_EN
        pend_ts_d  = pend_ts_q;
        if (|wrap && !(|pend_kept)) pend_ts_d = ts_q;
`endif
    end

    always_comb begin
        task_d = task_q;
        pace_d = pace_q;
        used_d = used_q;
        if (load) begin
            if (fifo_empty) begin
                task_d = '0;
`ifdef PACING_TIMESTAMP_EN
                task_d.stamp = pend_ts_q;
`endif
            end else begin
                task_d = fifo_rdata;
            end
            pace_d = pend_q;
            used_d = !fifo_empty;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)      state_d = ISSUE;
            ISSUE:   if (mon_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        mon_valid = (state_q == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            task_q     <= '0;
            pace_q     <= '0;
            used_q     <= 1'b0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            miss_q     <= 1'b0;
            for (int k = 0; k < NUM_PERIODS; k++) cnt_q[k] <= '0;
`ifdef PACING_TIMESTAMP_EN
            ts_q       <= '0;
            pend_ts_q  <= '0;
`endif
        end else begin
            task_q     <= task_d;
            pace_q     <= pace_d;
            used_q     <= used_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            miss_q     <= miss_d;
            for (int k = 0; k < NUM_PERIODS; k++) cnt_q[k] <= cnt_d[k];
`ifdef PACING_TIMESTAMP_EN
            ts_q       <= ts_q + TIME_W'(1);
            pend_ts_q  <= pend_ts_d;
`endif
        end
    end

    assign mon_has       = task_q.has;
    assign mon_data      = task_q.data;
    assign mon_pace      = pace_q;
    assign overflow      = overflow_q;
    assign deadline_miss = miss_q;
`ifdef PACING_TIMESTAMP_EN
    assign mon_time      = task_q.stamp;
`endif

endmodule

// File: tb/tb_pacing_scheduler.sv
// Scoreboard bench for pacing_scheduler: directed stimulus, expected tasks queued, monitor compares.
module tb_pacing_scheduler;
    import pacing_pkg::*;

    localparam int NP = 2;
    localparam int DW = NUM_INPUTS * DATA_W;

    typedef struct packed {
        logic [NUM_INPUTS-1:0] has;
        logic [DW-1:0]         data;
        logic [NP-1:0]         pace;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] x_data = '0;
    logic [2:0]    x_has = '0;
    logic          in_ready;
    logic          mon_valid;
    logic          mon_ready = 1'b0;
    logic [DW-1:0] mon_data;
    logic [2:0]    mon_has;
    logic [NP-1:0] mon_pace;
    logic          overflow;
    logic          deadline_miss;
`ifdef PACING_TIMESTAMP_EN
    logic [63:0]   mon_time;
`endif

    pacing_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .x_data        (x_data),
        .x_has         (x_has),
        .in_ready      (in_ready),
        .mon_valid     (mon_valid),
        .mon_ready     (mon_ready),
        .mon_data      (mon_data),
        .mon_has       (mon_has),
        .mon_pace      (mon_pace),
`ifdef PACING_TIMESTAMP_EN
        .mon_time      (mon_time),
`endif
        .overflow      (overflow),
        .deadline_miss (deadline_miss)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release
    int unsigned cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    exp_t exp_q[$];
    exp_t exp_head;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] has, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] d3, input logic [1:0] pace);
        exp_t e;
        e.has  = has;
        e.data = {d3, d2, d1};
        e.pace = pace;
        return e;
    endfunction

    // Monitor: a task accepted at the coming edge is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && mon_valid && mon_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_task: got has=%b data=%0h pace=%b, none expected",
                         mon_has, mon_data, mon_pace);
            end else begin
                exp_head = exp_q.pop_front();
                check("task", 128'({mon_has, mon_data, mon_pace}), 128'(exp_head));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one event for exactly one edge; call just after a rising edge.
    task automatic send(input logic [2:0] has, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3);
        x_has  = has;
        x_data = {d3, d2, d1};
        @(posedge clk);
        #1;
        x_has  = '0;
        x_data = '0;
    endtask

    task automatic wait_valid(input string name, input int budget, output int unsigned at);
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_valid) begin
                at = cyc;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: mon_valid not seen within %0d cycles", name, budget);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check(name, 128'(exp_q.size()), 128'(0));
    endtask

    int unsigned at;
    int unsigned push_at;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_valid", 128'(mon_valid), 128'(0));
        rst = 1'b0;
        en = 1'b1;
        mon_ready = 1'b1;

        // 1: idle after reset, first group-0 deadline
        tick(2);
        check("reset_task", 128'({mon_has, mon_data, mon_pace}), 128'(0));
        check("reset_sticky", 128'({overflow, deadline_miss}), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        exp_q.push_back(mk(3'b000, 0, 0, 0, 2'b01));
        wait_valid("t1_first_pace", 10100, at);
        // wrap on the 10000th counted edge sets pend, IDLE loads on the next edge
        check("t1_first_pace_cycle", 128'(at), 128'(10001));

        // 2: single event, stream 3 value masked off
        wait_cyc(10010);
        exp_q.push_back(mk(3'b011, 1, 2, 0, 2'b00));
        send(3'b011, 1, 2, 32'h77);
        push_at = cyc;
        wait_valid("t2_event", 10, at);
        check("t2_latency", 128'(at), 128'(push_at + 1));

        // 3: fill queue with monitor stalled, fifth event dropped
        wait_cyc(10020);
        mon_ready = 1'b0;
        send(3'b001, 10, 32'h55, 0);
        send(3'b010, 32'h66, 20, 0);
        send(3'b100, 0, 0, 30);
        send(3'b111, 40, 41, 42);
        send(3'b101, 50, 51, 52);
        check("t3_in_ready_full", 128'(in_ready), 128'(0));
        check("t3_overflow", 128'(overflow), 128'(1));
        exp_q.push_back(mk(3'b001, 10, 0, 0, 2'b00));
        exp_q.push_back(mk(3'b010, 0, 20, 0, 2'b00));
        exp_q.push_back(mk(3'b100, 0, 0, 30, 2'b00));
        exp_q.push_back(mk(3'b111, 40, 41, 42, 2'b00));
        mon_ready = 1'b1;
        wait_drain("t3_drained", 40);
        tick(2);
        check("t3_in_ready_empty", 128'(in_ready), 128'(1));

        // 4: event pushed on the group-0 wrap edge merges into one task
        wait_cyc(19999);
        exp_q.push_back(mk(3'b110, 0, 7, 8, 2'b01));
        send(3'b110, 32'h99, 7, 8);
        wait_valid("t4_merge", 10, at);
        check("t4_merge_cycle", 128'(at), 128'(20001));
        exp_q.push_back(mk(3'b000, 0, 0, 0, 2'b01));
        exp_q.push_back(mk(3'b000, 0, 0, 0, 2'b01));

        // 5: both groups due at edge 50000, monitor stalled for 20001 edges
        wait_cyc(49999);
        check("t5_prior_drained", 128'(exp_q.size()), 128'(0));
        mon_ready = 1'b0;
        exp_q.push_back(mk(3'b000, 0, 0, 0, 2'b11));
        wait_cyc(50500);
        check("t5_held_task", 128'({mon_valid, mon_pace}), 128'(3'b111));
        check("t5_no_miss_yet", 128'(deadline_miss), 128'(0));
        wait_cyc(60100);
        check("t5_miss", 128'(deadline_miss), 128'(1));
        wait_cyc(70000);
        mon_ready = 1'b1;
        tick(3);
        check("t5_drained", 128'(exp_q.size()), 128'(0));
        check("t5_single_task", 128'(mon_valid), 128'(0));

        // 6: asynchronous reset during a held handshake
        wait_cyc(70010);
        mon_ready = 1'b0;
        send(3'b001, 5, 0, 0);
        send(3'b010, 0, 6, 0);
        wait_valid("t6_held", 10, at);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid_async", 128'(mon_valid), 128'(0));
        check("t6_outputs_reset", 128'({in_ready, overflow, deadline_miss, mon_has, mon_pace}),
              128'({1'b1, 1'b0, 1'b0, 3'b000, 2'b00}));
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_ready = 1'b1;
        tick(20);
        check("t6_queue_empty", 128'(mon_valid), 128'(0));
        check("final_scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
